// File: rtl/hc_request_sched.sv
// Round-robin scheduler sharing one read/write requestor between NUM_REQ command ports.
// Define HC_SCHED_TIMEOUT_EN to add a BUSY watchdog that aborts stuck commands.
module hc_request_sched #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][68:0]       req_ctrl,
  output logic [NUM_REQ-1:0]             req_grant,
  output logic [NUM_REQ-1:0]             req_done,
  output logic                           req_err,
  output logic                           out_valid,
  output logic [68:0]                    out_ctrl,
  input  logic                           out_ready,
  input  logic                           out_done,
  output logic                           busy,
  output logic [$clog2(NUM_REQ)-1:0]     owner,
  output logic                           timeout_err
);

  localparam int unsigned OwnerW = $clog2(NUM_REQ);

  // t_request_control layout: {cmd[68:66], id[65:64], size[63:32], offset[31:0]}
  localparam logic [2:0] CmdIdle       = 3'd0;
  localparam logic [2:0] CmdMaxDefined = 3'd4;

  typedef enum logic [1:0] {StIdle, StIssue, StBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic [OwnerW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OwnerW-1:0]   owner_q, owner_d;
  logic [68:0]         out_ctrl_q, out_ctrl_d;
  logic                out_valid_q, out_valid_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q, done_d;

  logic                sel_found;
  logic [OwnerW-1:0]   sel_idx;
  logic [OwnerW-1:0]   cand_idx;
  logic [68:0]         sel_ctrl;
  logic [2:0]          sel_cmd;
  logic [31:0]         sel_size;
  logic                sel_noop;
  logic [OwnerW-1:0]   rr_next;

`ifdef HC_SCHED_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        req_err_q, req_err_d;
  logic        timeout_err_q, timeout_err_d;
`endif

  // First valid port at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_idx = OwnerW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!sel_found && req_valid[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  assign sel_ctrl = req_ctrl[sel_idx];
  assign sel_cmd  = sel_ctrl[68:66];
  assign sel_size = sel_ctrl[63:32];
  // Idle and undefined commands, or zero-length transfers, never reach the requestor.
  assign sel_noop = (sel_cmd == CmdIdle) || (sel_cmd > CmdMaxDefined) || (sel_size == '0);

  assign rr_next = (owner_q == OwnerW'(NUM_REQ - 1)) ? '0 : owner_q + OwnerW'(1);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    out_ctrl_d  = out_ctrl_q;
    out_valid_d = out_valid_q;
    grant_d     = '0;
    done_d      = '0;
`ifdef HC_SCHED_TIMEOUT_EN
    cnt_d         = cnt_q;
    err_d         = err_q;
    req_err_d     = 1'b0;
    timeout_err_d = timeout_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (enable && sel_found) begin
          grant_d[sel_idx] = 1'b1;
          out_ctrl_d       = sel_ctrl;
          owner_d          = sel_idx;
          if (sel_noop) begin
            state_d = StDone;
          end else begin
            out_valid_d = 1'b1;
            state_d     = StIssue;
          end
        end
      end
      StIssue: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StBusy;
`ifdef HC_SCHED_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      StBusy: begin
        if (out_done) begin
          state_d = StDone;
        end
`ifdef HC_SCHED_TIMEOUT_EN
        // Abort on the edge where the counter would reach TIMEOUT_CYCLES-1.
        else if (cnt_q + 32'd1 >= 32'(TIMEOUT_CYCLES) - 32'd1) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
`endif
      end
      StDone: begin
        done_d[owner_q] = 1'b1;
        rr_ptr_d        = rr_next;
        state_d         = StIdle;
`ifdef HC_SCHED_TIMEOUT_EN
        req_err_d = err_q;
        err_d     = 1'b0;
        if (err_q) begin
          timeout_err_d = 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      out_ctrl_q  <= '0;
      out_valid_q <= 1'b0;
      grant_q     <= '0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      out_ctrl_q  <= out_ctrl_d;
      out_valid_q <= out_valid_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
    end
  end

`ifdef HC_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      err_q         <= 1'b0;
      req_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      req_err_q     <= req_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign req_err     = req_err_q;
  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign req_err            = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  assign req_grant = grant_q;
  assign req_done  = done_q;
  assign out_valid = out_valid_q;
  assign out_ctrl  = out_ctrl_q;
  assign owner     = owner_q;
  assign busy      = (state_q != StIdle);

endmodule
